cpu_bus_arbiter: RTL and testbench

Sequences ownership of the 6502 external bus (address, data, RWn) between the CPU core and one DMA requester (video fetch, blitter, debug port). It drives the core's RDY and AEC inputs so the CPU halts on a read cycle before the bus is tri-stated and handed over. It also enforces a CPU holdoff window after every grant, and optionally a maximum grant length. It sits between chip_top's pad ring and the 6502 core, alongside the design_sel mux.

---
 rtl/cpu_bus_arbiter.sv | 129 ++++++++++++
 tb/tb_cpu_bus_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_arbiter.sv
// rtl/cpu_bus_arbiter.sv - 6502 bus ownership arbiter between the CPU core and one DMA requester.
// Define ARB_TIMEOUT_EN to bound each grant to GRANT_MAX cycles.
module cpu_bus_arbiter #(
    parameter int unsigned HOLDOFF_CYCLES = 4,
    parameter int unsigned GRANT_MAX      = 64,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        RESETn,
    input  logic        cpu_rwn,
    output logic        cpu_rdy,
    output logic        cpu_aec,
    input  logic        dma_req,
    output logic        dma_gnt,
    output logic        dma_timeout,
    output logic [15:0] busy_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STALL,
        S_HANDOFF,
        S_GRANT,
        S_RELEASE,
        S_HOLDOFF
    } state_t;

    localparam int unsigned CNT_NEED = (GRANT_MAX > HOLDOFF_CYCLES) ? GRANT_MAX : HOLDOFF_CYCLES;
    localparam logic [CNT_W-1:0] HOLD_LAST =
        CNT_W'((HOLDOFF_CYCLES > 0) ? (HOLDOFF_CYCLES - 1) : 0);
`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] GRANT_LAST = CNT_W'(GRANT_MAX);
`endif

    generate
        if ($clog2(CNT_NEED + 1) > CNT_W) begin : g_cnt_w_too_small
            $error("CNT_W cannot hold max(GRANT_MAX, HOLDOFF_CYCLES)");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             timeout_d;

    // The one counter serves as grant-length counter in GRANT and holdoff countdown in HOLDOFF.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        armed_d   = armed_q | ~dma_req;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dma_req && armed_q) begin
                    state_d = S_STALL;
                end
            end
            S_STALL: begin
                if (!dma_req) begin
                    state_d = S_IDLE;
                end else if (cpu_rwn) begin
                    state_d = S_HANDOFF;
                end
            end
            S_HANDOFF: begin
                state_d = S_GRANT;
                cnt_d   = CNT_W'(1);
            end
            S_GRANT: begin
                if (!dma_req) begin
                    state_d = S_RELEASE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == GRANT_LAST) begin
                    state_d   = S_RELEASE;
                    timeout_d = 1'b1;
                    armed_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_RELEASE: begin
                if (HOLDOFF_CYCLES == 0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLDOFF;
                    cnt_d   = HOLD_LAST;
                end
            end
            S_HOLDOFF: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            armed_q     <= 1'b1;
            cpu_rdy     <= 1'b1;
            cpu_aec     <= 1'b1;
            dma_gnt     <= 1'b0;
            dma_timeout <= 1'b0;
            busy_cycles <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            armed_q     <= armed_d;
            cpu_rdy     <= (state_d == S_IDLE) || (state_d == S_HOLDOFF);
            cpu_aec     <= !((state_d == S_HANDOFF) || (state_d == S_GRANT));
            dma_gnt     <= (state_d == S_GRANT);
            dma_timeout <= timeout_d;
            if (!cpu_rdy && (busy_cycles != 16'hFFFF)) begin
                busy_cycles <= busy_cycles + 16'h0001;
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb/tb_cpu_bus_arbiter.sv - randomized and directed bench for cpu_bus_arbiter against a sequential reference model.
module tb_cpu_bus_arbiter;

    localparam int HOLD = 4;
    localparam int GMAX = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        RESETn = 1'b0;
    logic        cpu_rwn = 1'b1;
    logic        dma_req = 1'b0;
    logic        cpu_rdy, cpu_aec, dma_gnt, dma_timeout;
    logic [15:0] busy_cycles;

    cpu_bus_arbiter #(
        .HOLDOFF_CYCLES(HOLD),
        .GRANT_MAX     (GMAX),
        .CNT_W         (8)
    ) dut (
        .clk        (clk),
        .RESETn     (RESETn),
        .cpu_rwn    (cpu_rwn),
        .cpu_rdy    (cpu_rdy),
        .cpu_aec    (cpu_aec),
        .dma_req    (dma_req),
        .dma_gnt    (dma_gnt),
        .dma_timeout(dma_timeout),
        .busy_cycles(busy_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: walks the bus-handover sequence one sampled edge at a time.
    bit e_rdy = 1'b1, e_aec = 1'b1, e_gnt = 1'b0, e_to = 1'b0;
    int e_busy = 0;
    bit m_armed = 1'b1;

    task automatic m_edge(output bit rst, output bit req, output bit rwn, output bit arm);
        @(posedge clk);
        rst = !RESETn;
        req = dma_req;
        rwn = cpu_rwn;
        arm = m_armed;
        if (!rst) begin
            if (!e_rdy && e_busy != 16'hFFFF) e_busy++;
            if (!req) m_armed = 1'b1;
        end
    endtask

    task automatic mdl_run();
        bit rst, req, rwn, arm, timed;
        int n;
        forever begin
            e_rdy = 1'b1; e_aec = 1'b1; e_gnt = 1'b0; e_to = 1'b0;
            do begin
                m_edge(rst, req, rwn, arm);
                if (rst) return;
            end while (!(req && arm));
            e_rdy = 1'b0;
            forever begin
                m_edge(rst, req, rwn, arm);
                if (rst) return;
                if (!req || rwn) break;
            end
            if (!req) continue;
            e_aec = 1'b0;
            m_edge(rst, req, rwn, arm);
            if (rst) return;
            e_gnt = 1'b1;
            n = 0;
            timed = 1'b0;
            forever begin
                m_edge(rst, req, rwn, arm);
                if (rst) return;
                n++;
                if (!req) break;
                if (TO_EN && n == GMAX) begin
                    timed = 1'b1;
                    m_armed = 1'b0;
                    break;
                end
            end
            e_gnt = 1'b0; e_aec = 1'b1; e_to = timed;
            m_edge(rst, req, rwn, arm);
            if (rst) return;
            e_to = 1'b0; e_rdy = 1'b1;
            repeat (HOLD) begin
                m_edge(rst, req, rwn, arm);
                if (rst) return;
            end
        end
    endtask

    always begin
        e_rdy = 1'b1; e_aec = 1'b1; e_gnt = 1'b0; e_to = 1'b0;
        e_busy = 0;
        m_armed = 1'b1;
        wait (RESETn === 1'b1);
        mdl_run();
    end

    always @(negedge clk) begin
        if (RESETn) begin
            check("model_rdy", cpu_rdy, e_rdy);
            check("model_aec", cpu_aec, e_aec);
            check("model_gnt", dma_gnt, e_gnt);
            check("model_timeout", dma_timeout, e_to);
            check("model_busy", busy_cycles, e_busy);
            check("inv_gnt_owns_bus", dma_gnt & (cpu_aec | cpu_rdy), 0);
            check("inv_aec_rdy", ~cpu_aec & cpu_rdy, 0);
        end
    end

    task automatic settle();
        @(negedge clk); #1;
        dma_req = 1'b0;
        cpu_rwn = 1'b1;
        repeat (HOLD + 6) @(negedge clk);
    endtask

    task automatic wait_gnt(input string tag);
        int k;
        k = 0;
        while (dma_gnt !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check(tag, dma_gnt, 1);
    endtask

    int  cnt, gcnt, tcnt, run_len;
    bit  saw_aec0, saw_gnt;

    initial begin
        repeat (2) @(negedge clk);
        check("reset_rdy", cpu_rdy, 1);
        check("reset_aec", cpu_aec, 1);
        check("reset_gnt", dma_gnt, 0);
        check("reset_timeout", dma_timeout, 0);
        check("reset_busy", busy_cycles, 0);
        #1 RESETn = 1'b1;

        // Minimum-latency handover and release.
        @(negedge clk); #1;
        dma_req = 1'b1; cpu_rwn = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("lat_rdy", cpu_rdy, 0);
            check("lat_aec", cpu_aec, (k == 1) ? 1 : 0);
            check("lat_gnt", dma_gnt, (k == 3) ? 1 : 0);
        end
        #1 dma_req = 1'b0;
        @(negedge clk);
        check("rel_gnt", dma_gnt, 0);
        check("rel_aec", cpu_aec, 1);
        check("rel_rdy", cpu_rdy, 0);
        @(negedge clk);
        check("rel_rdy_up", cpu_rdy, 1);
        check("rel_busy", busy_cycles, 4);
        settle();

        // Three CPU writes stretch STALL by three cycles.
        #1 dma_req = 1'b1; cpu_rwn = 1'b0;
        cnt = 0;
        while (dma_gnt !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
            if (cnt <= 4) check("wr_stall_aec", cpu_aec, 1);
            if (cnt == 4) #1 cpu_rwn = 1'b1;
        end
        check("wr_stall_latency", cnt, 6);
        settle();

        // Request withdrawn during writes: no handover.
        #1 dma_req = 1'b1; cpu_rwn = 1'b0;
        @(negedge clk); #1 dma_req = 1'b0;
        saw_aec0 = 1'b0; saw_gnt = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (!cpu_aec) saw_aec0 = 1'b1;
            if (dma_gnt) saw_gnt = 1'b1;
        end
        check("abort_aec_fell", saw_aec0, 0);
        check("abort_gnt_rose", saw_gnt, 0);
        check("abort_rdy", cpu_rdy, 1);
        settle();

        // Holdoff window after release with the request re-asserted at once.
        #1 dma_req = 1'b1; cpu_rwn = 1'b1;
        wait_gnt("hold_gnt");
        #1 dma_req = 1'b0;
        @(negedge clk); #1 dma_req = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (cpu_rdy === 1'b1 && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        check("holdoff_rdy_high", cnt, HOLD + 1);
        settle();

`ifdef ARB_TIMEOUT_EN
        // Grant held past GRANT_MAX is revoked once and not re-issued while the request stays high.
        #1 dma_req = 1'b1; cpu_rwn = 1'b1;
        gcnt = 0; tcnt = 0;
        repeat (GMAX + HOLD + 20) begin
            @(negedge clk);
            if (dma_gnt) gcnt++;
            if (dma_timeout) tcnt++;
        end
        check("timeout_gnt_cycles", gcnt, GMAX);
        check("timeout_pulses", tcnt, 1);
        check("timeout_no_regrant_rdy", cpu_rdy, 1);
        #1 dma_req = 1'b0;
        @(negedge clk); #1 dma_req = 1'b1;
        wait_gnt("timeout_regrant");
        settle();
`endif

        // Reset in the middle of a grant hands the bus straight back.
        #1 dma_req = 1'b1; cpu_rwn = 1'b1;
        wait_gnt("rst_gnt");
        #1 RESETn = 1'b0;
        #1;
        check("midrst_rdy", cpu_rdy, 1);
        check("midrst_aec", cpu_aec, 1);
        check("midrst_gnt", dma_gnt, 0);
        check("midrst_busy", busy_cycles, 0);
        @(negedge clk); #1;
        dma_req = 1'b0;
        RESETn = 1'b1;

        // Random request bursts against a mostly-reading CPU.
        run_len = 0;
        repeat (2500) begin
            @(negedge clk); #1;
            if (run_len == 0) begin
                dma_req = ($urandom_range(0, 2) != 0);
                run_len = $urandom_range(1, 14);
            end
            run_len--;
            cpu_rwn = ($urandom_range(0, 3) != 0);
        end
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
